// File: rtl/mem2axi_burst.sv
// mem2axi_burst: bridges one MEM_DW-wide memory-bus read/write request onto AXI4 master traffic.
// Define MEM2AXI_BURST_EN for INCR bursts; otherwise each beat is its own single-beat transaction.
module mem2axi_burst #(
    parameter int unsigned MEM_DW = 128,
    parameter int unsigned AXI_DW = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned RD_ID  = 0,
    parameter int unsigned WR_ID  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_req,
    output logic                  r_rdy,
    input  logic [ADDR_W-1:0]     r_addr,
    input  logic [3:0]            r_type,
    output logic [MEM_DW-1:0]     re_data,
    output logic                  re_valid,
    output logic                  re_err,
    input  logic                  iw_req,
    output logic                  iw_rdy,
    input  logic [ADDR_W-1:0]     iw_addr,
    input  logic [3:0]            iw_type,
    input  logic [MEM_DW-1:0]     iw_data,
    input  logic [MEM_DW/8-1:0]   iw_strb,
    output logic                  iw_done,
    output logic                  iw_err,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic [ID_W-1:0]       ar_id,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic [ID_W-1:0]       r_id,
    input  logic [AXI_DW-1:0]     r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic [ADDR_W-1:0]     aw_addr,
    output logic [ID_W-1:0]       aw_id,
    output logic [7:0]            aw_len,
    output logic [2:0]            aw_size,
    output logic [1:0]            aw_burst,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [AXI_DW-1:0]     w_data,
    output logic [AXI_DW/8-1:0]   w_strb,
    output logic                  w_last,
    output logic                  w_valid,
    input  logic                  w_ready,
    input  logic [ID_W-1:0]       b_id,
    input  logic [1:0]            b_resp,
    input  logic                  b_valid,
    output logic                  b_ready
);
    localparam int unsigned RATIO     = MEM_DW / AXI_DW;
    localparam int unsigned AXI_BYTES = AXI_DW / 8;
    localparam int unsigned AXI_SIZE  = $clog2(AXI_BYTES);
`ifdef MEM2AXI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam logic [1:0] RD_IDLE = 2'd0, RD_AR   = 2'd1, RD_DATA = 2'd2;
    localparam logic [1:0] WR_IDLE = 2'd0, WR_AD   = 2'd1, WR_RESP = 2'd2;

    function automatic logic [4:0] req_bytes(input logic [3:0] t);
        case (t)
            4'd1, 4'd3, 4'd7, 4'd15: req_bytes = 5'(t) + 5'd1;
            default:                 req_bytes = 5'd1;
        endcase
    endfunction

    function automatic logic [7:0] calc_beats(input logic [3:0] t);
        int unsigned n;
        n = 32'(req_bytes(t)) / AXI_BYTES;
        if (n <= 1)          calc_beats = 8'd1;
        else if (n > RATIO)  calc_beats = 8'(RATIO);
        else                 calc_beats = 8'(n);
    endfunction

    function automatic logic [2:0] calc_size(input logic [3:0] t);
        logic [4:0] b;
        b = req_bytes(t);
        if (32'(b) >= AXI_BYTES) calc_size = 3'(AXI_SIZE);
        else begin
            case (b)
                5'd2:    calc_size = 3'd1;
                5'd4:    calc_size = 3'd2;
                5'd8:    calc_size = 3'd3;
                default: calc_size = 3'd0;
            endcase
        end
    endfunction

    function automatic logic [AXI_DW-1:0] data_beat(input logic [MEM_DW-1:0] d, input logic [7:0] k);
        data_beat = '0;
        for (int unsigned i = 0; i < RATIO; i++)
            if (k == 8'(i)) data_beat = d[i*AXI_DW +: AXI_DW];
    endfunction

    function automatic logic [AXI_DW/8-1:0] strb_beat(input logic [MEM_DW/8-1:0] s, input logic [7:0] k);
        strb_beat = '0;
        for (int unsigned i = 0; i < RATIO; i++)
            if (k == 8'(i)) strb_beat = s[i*AXI_BYTES +: AXI_BYTES];
    endfunction

    assign ar_id    = ID_W'(RD_ID);
    assign aw_id    = ID_W'(WR_ID);
    assign ar_burst = 2'b01;
    assign aw_burst = 2'b01;

    // Response IDs are not checked; r_last only matters in burst builds.
    logic unused_in;
    assign unused_in = ^{r_id, b_id, r_last};

    // ---------------- read path ----------------
    logic [1:0]        rd_state, rd_state_n;
    logic [7:0]        rd_beats, rd_beats_n, rd_cnt, rd_cnt_n;
    logic [ADDR_W-1:0] ar_addr_n;
    logic [7:0]        ar_len_n;
    logic [2:0]        ar_size_n;
    logic              ar_valid_n, r_ready_n, r_rdy_n, re_valid_n, re_err_n, rd_last;
    logic [MEM_DW-1:0] re_data_n;

    always_comb begin
        rd_state_n = rd_state;
        rd_beats_n = rd_beats;
        rd_cnt_n   = rd_cnt;
        ar_addr_n  = ar_addr;
        ar_len_n   = ar_len;
        ar_size_n  = ar_size;
        ar_valid_n = ar_valid;
        r_ready_n  = r_ready;
        r_rdy_n    = r_rdy;
        re_valid_n = 1'b0;
        re_err_n   = re_err;
        re_data_n  = re_data;
        rd_last    = BURST ? r_last : (rd_cnt == rd_beats - 8'd1);
        case (rd_state)
            RD_IDLE: if (r_req) begin
                rd_state_n = RD_AR;
                rd_beats_n = calc_beats(r_type);
                rd_cnt_n   = 8'd0;
                ar_addr_n  = r_addr;
                ar_len_n   = BURST ? calc_beats(r_type) - 8'd1 : 8'd0;
                ar_size_n  = calc_size(r_type);
                ar_valid_n = 1'b1;
                r_rdy_n    = 1'b0;
                re_err_n   = 1'b0;
                re_data_n  = '0;
            end
            RD_AR: if (ar_ready) begin
                rd_state_n = RD_DATA;
                ar_valid_n = 1'b0;
                r_ready_n  = 1'b1;
            end
            RD_DATA: if (r_valid) begin
                for (int unsigned k = 0; k < RATIO; k++)
                    if (rd_cnt == 8'(k)) re_data_n[k*AXI_DW +: AXI_DW] = r_data;
                re_err_n = re_err | (r_resp != 2'b00);
                rd_cnt_n = rd_cnt + 8'd1;
                r_ready_n = 1'b0;
                if (rd_last) begin
                    rd_state_n = RD_IDLE;
                    re_valid_n = 1'b1;
                    r_rdy_n    = 1'b1;
                end else if (BURST) begin
                    r_ready_n  = 1'b1;
                end else begin
                    // next single-beat transaction at the following AXI word
                    rd_state_n = RD_AR;
                    ar_addr_n  = ar_addr + ADDR_W'(AXI_BYTES);
                    ar_valid_n = 1'b1;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_beats <= 8'd1;
            rd_cnt   <= 8'd0;
            ar_addr  <= '0;
            ar_len   <= 8'd0;
            ar_size  <= 3'd0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            r_rdy    <= 1'b1;
            re_valid <= 1'b0;
            re_err   <= 1'b0;
            re_data  <= '0;
        end else begin
            rd_state <= rd_state_n;
            rd_beats <= rd_beats_n;
            rd_cnt   <= rd_cnt_n;
            ar_addr  <= ar_addr_n;
            ar_len   <= ar_len_n;
            ar_size  <= ar_size_n;
            ar_valid <= ar_valid_n;
            r_ready  <= r_ready_n;
            r_rdy    <= r_rdy_n;
            re_valid <= re_valid_n;
            re_err   <= re_err_n;
            re_data  <= re_data_n;
        end
    end

    // ---------------- write path ----------------
    logic [1:0]          wr_state, wr_state_n;
    logic [7:0]          wr_beats, wr_beats_n, wr_cnt, wr_cnt_n;
    logic [MEM_DW-1:0]   wr_data, wr_data_n;
    logic [MEM_DW/8-1:0] wr_strb, wr_strb_n;
    logic [ADDR_W-1:0]   aw_addr_n;
    logic [7:0]          aw_len_n;
    logic [2:0]          aw_size_n;
    logic [AXI_DW-1:0]   w_data_n;
    logic [AXI_DW/8-1:0] w_strb_n;
    logic                aw_valid_n, w_valid_n, w_last_n, b_ready_n, iw_rdy_n, iw_done_n, iw_err_n;
    logic                aw_done, aw_done_n, w_done, w_done_n, aw_hs, w_hs;

    assign aw_hs = aw_valid & aw_ready;
    assign w_hs  = w_valid & w_ready;

    always_comb begin
        wr_state_n = wr_state;
        wr_beats_n = wr_beats;
        wr_cnt_n   = wr_cnt;
        wr_data_n  = wr_data;
        wr_strb_n  = wr_strb;
        aw_addr_n  = aw_addr;
        aw_len_n   = aw_len;
        aw_size_n  = aw_size;
        aw_valid_n = aw_valid;
        w_valid_n  = w_valid;
        w_data_n   = w_data;
        w_strb_n   = w_strb;
        w_last_n   = w_last;
        b_ready_n  = b_ready;
        iw_rdy_n   = iw_rdy;
        iw_done_n  = 1'b0;
        iw_err_n   = iw_err;
        aw_done_n  = aw_done;
        w_done_n   = w_done;
        case (wr_state)
            WR_IDLE: if (iw_req) begin
                wr_state_n = WR_AD;
                wr_beats_n = calc_beats(iw_type);
                wr_cnt_n   = 8'd0;
                wr_data_n  = iw_data;
                wr_strb_n  = iw_strb;
                aw_addr_n  = iw_addr;
                aw_len_n   = BURST ? calc_beats(iw_type) - 8'd1 : 8'd0;
                aw_size_n  = calc_size(iw_type);
                aw_valid_n = 1'b1;
                w_valid_n  = 1'b1;
                w_data_n   = data_beat(iw_data, 8'd0);
                w_strb_n   = strb_beat(iw_strb, 8'd0);
                w_last_n   = BURST ? (calc_beats(iw_type) == 8'd1) : 1'b1;
                aw_done_n  = 1'b0;
                w_done_n   = 1'b0;
                iw_rdy_n   = 1'b0;
                iw_err_n   = 1'b0;
            end
            WR_AD: begin
                if (aw_hs) begin
                    aw_valid_n = 1'b0;
                    aw_done_n  = 1'b1;
                end
                if (w_hs) begin
                    if (w_last) begin
                        w_valid_n = 1'b0;
                        w_done_n  = 1'b1;
                    end else begin
                        wr_cnt_n = wr_cnt + 8'd1;
                        w_data_n = data_beat(wr_data, wr_cnt + 8'd1);
                        w_strb_n = strb_beat(wr_strb, wr_cnt + 8'd1);
                        w_last_n = (wr_cnt + 8'd1 == wr_beats - 8'd1);
                    end
                end
                // AW and the final W may finish in either order or together
                if ((aw_done || aw_hs) && (w_done || (w_hs && w_last))) begin
                    wr_state_n = WR_RESP;
                    b_ready_n  = 1'b1;
                end
            end
            WR_RESP: if (b_valid) begin
                b_ready_n = 1'b0;
                iw_err_n  = iw_err | (b_resp != 2'b00);
                if (BURST || wr_cnt == wr_beats - 8'd1) begin
                    wr_state_n = WR_IDLE;
                    iw_done_n  = 1'b1;
                    iw_rdy_n   = 1'b1;
                end else begin
                    wr_state_n = WR_AD;
                    wr_cnt_n   = wr_cnt + 8'd1;
                    aw_addr_n  = aw_addr + ADDR_W'(AXI_BYTES);
                    aw_valid_n = 1'b1;
                    w_valid_n  = 1'b1;
                    w_data_n   = data_beat(wr_data, wr_cnt + 8'd1);
                    w_strb_n   = strb_beat(wr_strb, wr_cnt + 8'd1);
                    w_last_n   = 1'b1;
                    aw_done_n  = 1'b0;
                    w_done_n   = 1'b0;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            wr_beats <= 8'd1;
            wr_cnt   <= 8'd0;
            wr_data  <= '0;
            wr_strb  <= '0;
            aw_addr  <= '0;
            aw_len   <= 8'd0;
            aw_size  <= 3'd0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            w_last   <= 1'b0;
            b_ready  <= 1'b0;
            iw_rdy   <= 1'b1;
            iw_done  <= 1'b0;
            iw_err   <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_state_n;
            wr_beats <= wr_beats_n;
            wr_cnt   <= wr_cnt_n;
            wr_data  <= wr_data_n;
            wr_strb  <= wr_strb_n;
            aw_addr  <= aw_addr_n;
            aw_len   <= aw_len_n;
            aw_size  <= aw_size_n;
            aw_valid <= aw_valid_n;
            w_valid  <= w_valid_n;
            w_data   <= w_data_n;
            w_strb   <= w_strb_n;
            w_last   <= w_last_n;
            b_ready  <= b_ready_n;
            iw_rdy   <= iw_rdy_n;
            iw_done  <= iw_done_n;
            iw_err   <= iw_err_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
        end
    end

endmodule

// File: tb/tb_mem2axi_burst.sv
// Directed bench for mem2axi_burst; expectations follow MEM2AXI_BURST_EN when it is defined.
module tb_mem2axi_burst;
`ifdef MEM2AXI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         r_req, r_rdy, re_valid, re_err;
    logic [31:0]  r_addr;
    logic [3:0]   r_type;
    logic [127:0] re_data;
    logic         iw_req, iw_rdy, iw_done, iw_err;
    logic [31:0]  iw_addr;
    logic [3:0]   iw_type;
    logic [127:0] iw_data;
    logic [15:0]  iw_strb;
    logic [31:0]  ar_addr, aw_addr;
    logic [3:0]   ar_id, aw_id, r_id, b_id;
    logic [7:0]   ar_len, aw_len;
    logic [2:0]   ar_size, aw_size;
    logic [1:0]   ar_burst, aw_burst, r_resp, b_resp;
    logic         ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic         aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic [63:0]  r_data, w_data;
    logic [7:0]   w_strb;

    int n_checks = 0;
    int n_fail   = 0;

    mem2axi_burst dut (
        .clk(clk), .rst_n(rst_n),
        .r_req(r_req), .r_rdy(r_rdy), .r_addr(r_addr), .r_type(r_type),
        .re_data(re_data), .re_valid(re_valid), .re_err(re_err),
        .iw_req(iw_req), .iw_rdy(iw_rdy), .iw_addr(iw_addr), .iw_type(iw_type),
        .iw_data(iw_data), .iw_strb(iw_strb), .iw_done(iw_done), .iw_err(iw_err),
        .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave side: wait for AR, check its fields, accept it with a one-cycle ar_ready.
    task automatic ar_accept(input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es);
        int n = 0;
        while (!ar_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ar_seen", 128'(ar_valid), 128'(1));
        check("ar_addr", 128'(ar_addr), 128'(ea));
        check("ar_len", 128'(ar_len), 128'(el));
        check("ar_size", 128'(ar_size), 128'(es));
        check("ar_burst", 128'(ar_burst), 128'(2'b01));
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
    endtask

    // Slave side: wait for r_ready, present one R beat for one cycle.
    task automatic rd_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
        int n = 0;
        while (!r_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("r_ready", 128'(r_ready), 128'(1));
        r_valid = 1'b1;
        r_data  = d;
        r_resp  = resp;
        r_last  = last;
        @(negedge clk);
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        r_req = 1'b0; r_addr = '0; r_type = '0;
        iw_req = 1'b0; iw_addr = '0; iw_type = '0; iw_data = '0; iw_strb = '0;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_id = 4'd0; r_data = '0; r_resp = '0; r_last = 1'b0; r_valid = 1'b0;
        b_id = 4'd1; b_resp = '0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r_rdy", 128'(r_rdy), 128'(1));
        check("rst_iw_rdy", 128'(iw_rdy), 128'(1));
        check("rst_valids", 128'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 128'(0));
        check("rst_pulses", 128'({re_valid, iw_done, re_err, iw_err}), 128'(0));
        check("rst_re_data", re_data, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1/4: 16-byte read, one burst or two single beats
        r_req = 1'b1; r_addr = 32'h8000_0000; r_type = 4'd15;
        @(negedge clk);
        r_req = 1'b0;
        check("t1_r_rdy_low", 128'(r_rdy), 128'(0));
        ar_accept(32'h8000_0000, BURST ? 8'd1 : 8'd0, 3'd3);
        rd_beat(64'h1111_1111_1111_1111, 2'b00, !BURST);
`ifndef MEM2AXI_BURST_EN
        check("t4_no_early_done", 128'(re_valid), 128'(0));
        ar_accept(32'h8000_0008, 8'd0, 3'd3);
`endif
        rd_beat(64'h2222_2222_2222_2222, 2'b00, 1'b1);
        check("t1_re_valid", 128'(re_valid), 128'(1));
        check("t1_re_data", re_data, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("t1_re_err", 128'(re_err), 128'(0));
        check("t1_r_rdy", 128'(r_rdy), 128'(1));
        @(negedge clk);
        check("t1_pulse_end", 128'(re_valid), 128'(0));

        // 2: 4-byte read with SLVERR
        r_req = 1'b1; r_addr = 32'h8000_0004; r_type = 4'd3;
        @(negedge clk);
        r_req = 1'b0;
        ar_accept(32'h8000_0004, 8'd0, 3'd2);
        rd_beat(64'hCAFE_F00D_1234_5678, 2'b10, 1'b1);
        check("t2_re_valid", 128'(re_valid), 128'(1));
        check("t2_re_err", 128'(re_err), 128'(1));
        check("t2_re_data", re_data, {64'h0, 64'hCAFE_F00D_1234_5678});
        @(negedge clk);

        // 3: 16-byte write, AW held off while W runs ahead
        iw_req = 1'b1; iw_addr = 32'h8000_0100; iw_type = 4'd15; iw_strb = 16'hFF0F;
        iw_data = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        @(negedge clk);
        iw_req = 1'b0;
        check("t3_iw_rdy_low", 128'(iw_rdy), 128'(0));
        check("t3_valids", 128'({aw_valid, w_valid}), 128'(2'b11));
        check("t3_w0_data", 128'(w_data), 128'(64'hAAAA_AAAA_AAAA_AAAA));
        check("t3_w0_strb", 128'(w_strb), 128'(8'h0F));
        check("t3_w0_last", 128'(w_last), 128'(!BURST));
        w_ready = 1'b1;
        @(negedge clk);
`ifdef MEM2AXI_BURST_EN
        check("t3_w1_data", 128'(w_data), 128'(64'hBBBB_BBBB_BBBB_BBBB));
        check("t3_w1_strb", 128'(w_strb), 128'(8'hFF));
        check("t3_w1_last", 128'(w_last), 128'(1));
        @(negedge clk);
`endif
        w_ready = 1'b0;
        check("t3_w_done", 128'(w_valid), 128'(0));
        check("t3_aw_pending", 128'(aw_valid), 128'(1));
        for (int i = 0; i < 3; i++) begin
            check("t3_no_b_ready", 128'(b_ready), 128'(0));
            @(negedge clk);
        end
        check("t3_aw_addr", 128'(aw_addr), 128'(32'h8000_0100));
        check("t3_aw_len", 128'(aw_len), 128'(BURST ? 8'd1 : 8'd0));
        check("t3_aw_size", 128'(aw_size), 128'(3'd3));
        aw_ready = 1'b1;
        @(negedge clk);
        aw_ready = 1'b0;
        check("t3_b_ready", 128'(b_ready), 128'(1));
        check("t3_aw_dropped", 128'(aw_valid), 128'(0));
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
`ifndef MEM2AXI_BURST_EN
        check("t4w_no_early_done", 128'(iw_done), 128'(0));
        check("t4w_aw1_addr", 128'(aw_addr), 128'(32'h8000_0108));
        check("t4w_w1_data", 128'(w_data), 128'(64'hBBBB_BBBB_BBBB_BBBB));
        check("t4w_w1_strb", 128'(w_strb), 128'(8'hFF));
        check("t4w_w1_last", 128'(w_last), 128'(1));
        aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        aw_ready = 1'b0; w_ready = 1'b0;
        check("t4w_straight_resp", 128'(b_ready), 128'(1));
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
`endif
        check("t3_iw_done", 128'(iw_done), 128'(1));
        check("t3_iw_err", 128'(iw_err), 128'(0));
        check("t3_iw_rdy", 128'(iw_rdy), 128'(1));
        @(negedge clk);
        check("t3_pulse_end", 128'(iw_done), 128'(0));

        // 5: read and write accepted together, AW/W/AR all handshake in one cycle
        r_req = 1'b1; r_addr = 32'hA000_0000; r_type = 4'd7;
        iw_req = 1'b1; iw_addr = 32'h9000_0000; iw_type = 4'd7; iw_strb = 16'hF0FF;
        iw_data = {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666};
        @(negedge clk);
        r_req = 1'b0; iw_req = 1'b0;
        check("t5_rdys_low", 128'({r_rdy, iw_rdy}), 128'(0));
        check("t5_valids", 128'({ar_valid, aw_valid, w_valid}), 128'(3'b111));
        check("t5_ar_addr", 128'(ar_addr), 128'(32'hA000_0000));
        check("t5_aw_addr", 128'(aw_addr), 128'(32'h9000_0000));
        check("t5_w", 128'({w_data, w_strb, w_last}), 128'({64'h6666_6666_6666_6666, 8'hFF, 1'b1}));
        ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        check("t5_readies", 128'({r_ready, b_ready}), 128'(2'b11));
        r_valid = 1'b1; r_data = 64'h7777_7777_7777_7777; r_last = 1'b1; r_resp = 2'b00;
        b_valid = 1'b1; b_resp = 2'b11;
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        check("t5_re_valid", 128'(re_valid), 128'(1));
        check("t5_re_data", re_data, {64'h0, 64'h7777_7777_7777_7777});
        check("t5_re_err", 128'(re_err), 128'(0));
        check("t5_iw_done", 128'(iw_done), 128'(1));
        check("t5_iw_err", 128'(iw_err), 128'(1));
        @(negedge clk);

        // 6: reset while waiting for read data
        r_req = 1'b1; r_addr = 32'h8000_0200; r_type = 4'd15;
        @(negedge clk);
        r_req = 1'b0;
        ar_accept(32'h8000_0200, BURST ? 8'd1 : 8'd0, 3'd3);
        check("t6_in_rdata", 128'(r_ready), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_valids", 128'({ar_valid, r_ready, aw_valid, w_valid, b_ready}), 128'(0));
        check("t6_rdys", 128'({r_rdy, iw_rdy}), 128'(2'b11));
        check("t6_re_data", re_data, 128'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t6_no_re_valid", 128'(re_valid), 128'(0));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
